draw_arbiter: RTL



---
 rtl/draw_pkg.sv | 32 +++
 rtl/hit_frame_latch.sv | 31 +++
 rtl/draw_arbiter.sv | 56 +++++
 3 files changed

// File: rtl/draw_pkg.sv
// Shared constants and hit-vector decoding for the draw arbiter and its consumers.
// Hit bits are only ever located through pair_index()/border_index().
package draw_pkg;

  localparam int RGB_WIDTH_DEF  = 8;
  localparam int NUM_LAYERS_DEF = 4;

  localparam logic [7:0] TRANSPARENT = 8'hFF;
  localparam logic [7:0] BLACK       = 8'h00;

  localparam int PLAYER  = 0;
  localparam int MISSILE = 1;
  localparam int ENEMY   = 2;
  localparam int BUNKER  = 3;

  localparam int BORDER_MOVE = 0;
  localparam int BORDER_ZONE = 1;

  function automatic int num_pairs(int n = NUM_LAYERS_DEF);
    return n * (n - 1) / 2;
  endfunction

  // Row-major over i<j: rows before i hold (n-1)+(n-2)+...+(n-i) pairs.
  function automatic int pair_index(int i, int j, int n = NUM_LAYERS_DEF);
    return i * n - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

  function automatic int border_index(int i, int b, int n = NUM_LAYERS_DEF);
    return num_pairs(n) + 2 * i + b;
  endfunction

endpackage

// File: rtl/hit_frame_latch.sv
// Per-frame hit gating: first-occurrence pulses and a snapshot of the previous frame.
module hit_frame_latch #(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         startOfFrame,
  input  logic [W-1:0] cur_hit,
  output logic [W-1:0] hit_pulse,
  output logic [W-1:0] hit_frame
);

  logic [W-1:0] hit_seen;
  logic [W-1:0] seen_eff;

  // The start-of-frame pixel already belongs to the new frame.
  assign seen_eff = startOfFrame ? '0 : hit_seen;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hit_seen  <= '0;
      hit_pulse <= '0;
      hit_frame <= '0;
    end else begin
      hit_pulse <= cur_hit & ~seen_eff;
      hit_seen  <= seen_eff | cur_hit;
      if (startOfFrame) hit_frame <= hit_seen;
    end
  end

endmodule

// File: rtl/draw_arbiter.sv
// Priority merge of object layers over the background, plus overlap/border hit
// detection reported once per frame.
module draw_arbiter
  import draw_pkg::*;
#(
  parameter int NUM_LAYERS = 4,
  parameter int RGB_WIDTH  = RGB_WIDTH_DEF,
  localparam int PAIRS     = NUM_LAYERS * (NUM_LAYERS - 1) / 2,
  localparam int HIT_WIDTH = PAIRS + 2 * NUM_LAYERS
) (
  input  logic                            clk,
  input  logic                            resetN,
  input  logic                            startOfFrame,
  input  logic [NUM_LAYERS-1:0]           layer_dr,
  input  logic [NUM_LAYERS*RGB_WIDTH-1:0] layer_RGB,
  input  logic [RGB_WIDTH-1:0]            background_RGB,
  input  logic [1:0]                      bordersDR,
  output logic [RGB_WIDTH-1:0]            RGBout,
  output logic [HIT_WIDTH-1:0]            hit_pulse,
  output logic [HIT_WIDTH-1:0]            hit_frame
);

  logic [RGB_WIDTH-1:0] sel_rgb;
  logic [HIT_WIDTH-1:0] cur_hit;

  // Walk from the lowest priority up so the lowest requesting index wins.
  always_comb begin
    sel_rgb = background_RGB;
    for (int i = NUM_LAYERS - 1; i >= 0; i--)
      if (layer_dr[i]) sel_rgb = layer_RGB[i*RGB_WIDTH +: RGB_WIDTH];
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) RGBout <= RGB_WIDTH'(BLACK);
    else         RGBout <= sel_rgb;
  end

  for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_layer
    for (genvar j = i + 1; j < NUM_LAYERS; j++) begin : g_pair
      assign cur_hit[pair_index(i, j, NUM_LAYERS)] = layer_dr[i] & layer_dr[j];
    end
    for (genvar b = 0; b < 2; b++) begin : g_border
      assign cur_hit[border_index(i, b, NUM_LAYERS)] = layer_dr[i] & bordersDR[b];
    end
  end

  hit_frame_latch #(.W(HIT_WIDTH)) u_latch (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .cur_hit      (cur_hit),
    .hit_pulse    (hit_pulse),
    .hit_frame    (hit_frame)
  );

endmodule
